// File: rtl/fixed_pkg.sv
// fixed_pkg: shared fixed-point constants and lerp operand types
package fixed_pkg;
  localparam int FIXED_WIDTH = 32;
  localparam int FIXED_FRAC_WIDTH = 16;
  localparam logic signed [FIXED_WIDTH-1:0] FIXED_ONE = FIXED_WIDTH'(1) << FIXED_FRAC_WIDTH;
  localparam logic signed [FIXED_WIDTH-1:0] FIXED_ZERO = '0;
  typedef struct packed {
    logic signed [FIXED_WIDTH-1:0] Value;
  } fixed_t;
  typedef struct packed {
    fixed_t a0;
    fixed_t a1;
    logic   dz;
  } lerp_operand_t;
endpackage

// File: rtl/fixed_lerp_operand_fifo.sv
// fixed_lerp_operand_fifo: in-order operand FIFO with count/full/empty and async reset
module fixed_lerp_operand_fifo #(
  parameter int DEPTH = 16,
  parameter type T = logic
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  T                        wdata,
  output T                        rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem_q[rptr_q];
  assign count = count_q;
  // next pointers wrap for free because DEPTH is a power of two
  always_comb begin
    wptr_d = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = do_pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // payload storage, no reset needed since reads are gated by count
  always_ff @(posedge clk)
    if (do_push) mem_q[wptr_q] <= wdata;
  // pointer and occupancy state
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
endmodule

// File: rtl/fixed_lerp_combine.sv
// fixed_lerp_combine: pairs divider quotients with queued operands and computes a0 + (a1 - a0) * t
module fixed_lerp_combine
  import fixed_pkg::*;
#(
  parameter int WIDTH = FIXED_WIDTH,
  parameter int FRAC = FIXED_FRAC_WIDTH,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_a0,
  input  logic [WIDTH-1:0]        in_a1,
  input  logic                    in_dz,
  input  logic                    div_valid,
  input  logic [WIDTH-1:0]        div_quot,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_value,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    err_orphan
);
  localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;
  localparam logic signed [2*WIDTH:0] RND = (2*WIDTH+1)'(1) << (FRAC-1);
  typedef struct packed {
    logic signed [WIDTH-1:0] a0;
    logic signed [WIDTH-1:0] a1;
    logic                    dz;
  } op_t;
  op_t wr, rd;
  logic full, empty, push, pop;
  logic signed [WIDTH:0] diff_q, diff_d;
  logic signed [WIDTH-1:0] t_q, t_d, a0_q, q;
  logic signed [2*WIDTH:0] prod;
  logic [WIDTH-1:0] out_value_q, out_d;
  logic v1_q, out_valid_q, err_q;
  assign wr = '{a0: in_a0, a1: in_a1, dz: in_dz};
  assign in_ready = !full;
  assign push = in_valid && !full;
  assign pop = div_valid && !empty;
  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign err_orphan = err_q;
  fixed_lerp_operand_fifo #(.DEPTH(DEPTH), .T(op_t)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wdata(wr),
    .rdata(rd),
    .count(occupancy),
    .full(full),
    .empty(empty)
  );
  // clamp t into [0, ONE], zero-divisor forces t=0; product is rounded half up
  always_comb begin
    q = $signed(div_quot);
    t_d = (rd.dz || q < 0) ? '0 : (q > ONE) ? ONE : q;
    diff_d = (WIDTH+1)'(rd.a1) - (WIDTH+1)'(rd.a0);
    prod = (2*WIDTH+1)'(diff_q) * (2*WIDTH+1)'(t_q);
    out_d = a0_q + WIDTH'((prod + RND) >>> FRAC);
  end
  // two-stage pipeline: operand/clamp capture, then multiply-accumulate; sticky orphan flag
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      v1_q <= 1'b0;
      out_valid_q <= 1'b0;
      err_q <= 1'b0;
      diff_q <= '0;
      t_q <= '0;
      a0_q <= '0;
      out_value_q <= '0;
    end else begin
      v1_q <= pop;
      out_valid_q <= v1_q;
      err_q <= err_q || (div_valid && empty);
      if (pop) begin
        diff_q <= diff_d;
        t_q <= t_d;
        a0_q <= rd.a0;
      end
      if (v1_q) out_value_q <= out_d;
    end
endmodule

// File: tb/tb_fixed_lerp_combine.sv
// tb_fixed_lerp_combine: scoreboard bench with a plain-arithmetic lerp reference model
module tb_fixed_lerp_combine;
  localparam int WIDTH = 32;
  localparam int FRAC = 16;
  localparam int DEPTH = 16;
  logic clk = 0, reset = 1, in_valid = 0, in_dz = 0, div_valid = 0;
  logic [31:0] in_a0 = 0, in_a1 = 0, div_quot = 0;
  logic in_ready, out_valid, err_orphan;
  logic [31:0] out_value;
  logic [4:0] occupancy;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct { logic [31:0] a0, a1; logic dz; } op_t;
  typedef struct { logic [31:0] v; int due; } exp_t;
  op_t opq[$];
  exp_t expq[$];
  logic orphan_m = 0;
  logic [31:0] last_v = 0;

  fixed_lerp_combine #(.WIDTH(WIDTH), .FRAC(FRAC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a0(in_a0), .in_a1(in_a1), .in_dz(in_dz), .div_valid(div_valid),
    .div_quot(div_quot), .out_valid(out_valid), .out_value(out_value),
    .occupancy(occupancy), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic longint floor_div(input longint n, input longint d);
    return (n >= 0) ? n / d : -((-n + d - 1) / d);
  endfunction

  function automatic logic [31:0] ref_lerp(input logic [31:0] a0, a1, input logic dz, input logic [31:0] q);
    longint t, o;
    t = dz ? 0 : longint'($signed(q));
    if (t < 0) t = 0;
    if (t > 65536) t = 65536;
    o = longint'($signed(a0)) + floor_div((longint'($signed(a1)) - longint'($signed(a0))) * t + 32768, 65536);
    return o[31:0];
  endfunction

  function automatic logic [31:0] rand_t();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 65536));
      1: return 32'h0001_0000;
      2: return -32'($urandom_range(1, 1 << 20));
      default: return 32'(65537 + $urandom_range(0, 1 << 20));
    endcase
  endfunction

  // reference model: operand queue plus expected results, due one cycle after the stage-1 edge
  always @(posedge clk or posedge reset) begin : model
    int sz;
    op_t o;
    exp_t e;
    if (reset) begin
      opq.delete();
      expq.delete();
      orphan_m = 0;
      last_v = 0;
    end else begin
      cyc++;
      sz = opq.size();
      if (div_valid) begin
        if (sz > 0) begin
          o = opq.pop_front();
          e.v = ref_lerp(o.a0, o.a1, o.dz, div_quot);
          e.due = cyc + 1;
          expq.push_back(e);
        end else orphan_m = 1;
      end
      if (in_valid && sz < DEPTH) opq.push_back('{in_a0, in_a1, in_dz});
    end
  end

  // monitor: compares DUT outputs with the model away from the active edge
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      chk("occupancy", 32'(occupancy), 32'(opq.size()));
      chk("in_ready", 32'(in_ready), 32'(opq.size() < DEPTH));
      chk("err_orphan", 32'(err_orphan), 32'(orphan_m));
      if (out_valid) begin
        if (expq.size() == 0) chk("unexpected out_valid", 32'(out_valid), 32'd0);
        else begin
          e = expq.pop_front();
          chk("out_value", out_value, e.v);
          chk("latency", 32'(cyc), 32'(e.due));
          last_v = e.v;
        end
      end else begin
        chk("out_value hold", out_value, last_v);
        if (expq.size() > 0 && expq[0].due < cyc) begin
          chk("missing out_valid", 32'(out_valid), 32'd1);
          void'(expq.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic iv, input logic [31:0] a0, a1, input logic dz, input logic dv, input logic [31:0] q);
    @(posedge clk);
    #1;
    in_valid = iv; in_a0 = a0; in_a1 = a1; in_dz = dz; div_valid = dv; div_quot = q;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input logic [31:0] a0, a1, input logic dz);
    drive(1, a0, a1, dz, 0, 0);
  endtask

  task automatic dv(input logic [31:0] q);
    drive(0, 0, 0, 0, 1, q);
  endtask

  task automatic expect_out(input string name, input logic [31:0] v);
    idle();
    idle();
    chk({name, " valid"}, 32'(out_valid), 32'd1);
    chk(name, out_value, v);
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_value", out_value, 32'd0);
    chk("reset occupancy", 32'(occupancy), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset err_orphan", 32'(err_orphan), 32'd0);
    @(posedge clk);
    #1 reset = 0;
    push(32'h0001_0000, 32'h0003_0000, 0);
    idle();
    idle();
    dv(32'h0000_8000);
    expect_out("midpoint", 32'h0002_0000);
    repeat (3) push(32'h0004_0000, 32'hFFFC_0000, 0);
    dv(32'h0000_4000);
    expect_out("descending quarter", 32'h0002_0000);
    dv(32'h0002_0000);
    expect_out("clamp high", 32'hFFFC_0000);
    dv(32'hFFFF_0000);
    expect_out("clamp low", 32'h0004_0000);
    push(32'h0007_8000, 32'h0000_0000, 1);
    dv(32'h0005_0000);
    expect_out("zero divisor", 32'h0007_8000);
    push(32'h0000_0000, 32'h0000_0001, 0);
    dv(32'h0000_8000);
    expect_out("round half up", 32'h0000_0001);
    repeat (DEPTH + 3) push($urandom, $urandom, 1'($urandom_range(0, 1)));
    idle();
    chk("full in_ready", 32'(in_ready), 32'd0);
    chk("full occupancy", 32'(occupancy), 32'(DEPTH));
    repeat (DEPTH) dv(rand_t());
    repeat (4) idle();
    chk("drained occupancy", 32'(occupancy), 32'd0);
    chk("drained in_ready", 32'(in_ready), 32'd1);
    repeat (400) drive(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 7) == 0),
                       opq.size() > 0 && $urandom_range(0, 2) != 0, rand_t());
    repeat (DEPTH + 4) drive(0, 0, 0, 0, opq.size() > 0, rand_t());
    repeat (3) idle();
    dv(32'h0000_8000);
    idle();
    chk("orphan set", 32'(err_orphan), 32'd1);
    repeat (3) idle();
    chk("orphan sticky", 32'(err_orphan), 32'd1);
    chk("orphan no output", 32'(out_valid), 32'd0);
    repeat (4) push($urandom, $urandom, 0);
    dv(rand_t());
    dv(rand_t());
    dv(rand_t());
    chk("pre-reset out_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1;
    in_valid = 0;
    div_valid = 0;
    #1;
    chk("async reset out_valid", 32'(out_valid), 32'd0);
    chk("async reset occupancy", 32'(occupancy), 32'd0);
    chk("async reset err_orphan", 32'(err_orphan), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (5) idle();
    chk("post-reset occupancy", 32'(occupancy), 32'd0);
    chk("post-reset err_orphan", 32'(err_orphan), 32'd0);
    chk("leftover expected", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fixed_lerp_combine.md
Name: fixed_lerp_combine

Overview:
- Downstream stage of the fixed-point lerp divider.
- Consumes each divider quotient as the interpolation factor t and computes o = a0 + (a1 - a0) * t in signed fixed point.
- Holds each request's a0/a1 operands in an in-order FIFO for the duration of the divider latency.
- The divider has no backpressure, so this block throttles request issue through in_ready.

Parameters:
WIDTH, 32, total signed fixed-point width (FIXED_WIDTH)
FRAC, 16, fractional bits (FIXED_FRAC_WIDTH)
DEPTH, 16, operand FIFO entries; must be >= divider latency + 2, power of two

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  upstream issues a divide request this cycle (same strobe as divider tvalid)
in_ready  out  1  operand FIFO can accept; upstream must not strobe the divider when low
in_a0  in  WIDTH  lerp start value, signed fixed
in_a1  in  WIDTH  lerp end value, signed fixed
in_dz  in  1  divisor of this request was zero (divider was fed 1 instead)
div_valid  in  1  divider result valid (m_axis_dout_tvalid)
div_quot  in  WIDTH  quotient t, signed fixed with FRAC fraction bits
out_valid  out  1  result valid, one-cycle pulse per result
out_value  out  WIDTH  lerp result, signed fixed
occupancy  out  $clog2(DEPTH)+1  operands currently queued
err_orphan  out  1  sticky: div_valid arrived while FIFO empty

Behaviour:
- Reset values (async assert, sync release): FIFO empty, occupancy=0, in_ready=1, out_valid=0, out_value=0, err_orphan=0, both pipeline valids=0.
- Push: in_valid && in_ready writes {in_a0, in_a1, in_dz}. in_valid while in_ready=0 is ignored (upstream protocol violation, no state change).
- in_ready = (occupancy < DEPTH). It is registered-free but does not depend on a same-cycle pop: a full FIFO refuses a push even when a pop occurs in that cycle.
- Pop: div_valid with FIFO non-empty pops the head entry and launches pipeline stage 1.
- div_valid with FIFO empty: no pop, no result; err_orphan set, cleared only by reset.
- Simultaneous push and pop: occupancy unchanged. Pointers wrap modulo DEPTH.
- Stage 1 (registered), clamp t:
  - in_dz=1 -> t=0;
  - t<0 -> t=0;
  - t>ONE (1<<FRAC) -> t=ONE;
  - diff = a1 - a0, sign-extended to WIDTH+1;
  - register diff, t, a0.
- Stage 2 (registered):
  - prod = diff * t, signed, 2*WIDTH+1 bits;
  - add rounding constant 1<<(FRAC-1);
  - arithmetic shift right by FRAC;
  - out_value = a0 + shifted, truncated to WIDTH.
  - Result is always within [min(a0,a1), max(a0,a1)], so no overflow is possible.
- Latency: div_valid at cycle N -> out_valid at N+2. Throughput is one result per cycle. Output order equals request order.
- out_value holds its last value while out_valid=0.
- Reset mid-operation clears the FIFO and pipeline. The divider must be reset in the same cycle, otherwise late quotients raise err_orphan.

Decomposition:
- Shared package fixed_pkg:
  - FIXED_WIDTH, FIXED_FRAC_WIDTH, FIXED_ONE, FIXED_ZERO;
  - Fixed typedef (struct with Value field);
  - lerp_operand_t struct {a0, a1, dz}.
- One sub-module, fixed_lerp_operand_fifo: synchronous FIFO with DEPTH and payload type parameters, outputs count/full/empty, same reset.
- Clamp and arithmetic stay inline in fixed_lerp_combine.

Test Plan (FRAC=16):
- Push a0=0x0001_0000, a1=0x0003_0000; 3 cycles later div_valid with t=0x0000_8000 -> out_value=0x0002_0000, exactly 2 cycles after div_valid.
- Descending and clamped: a0=0x0004_0000, a1=0xFFFC_0000 with t=0x0000_4000 -> 0x0002_0000; t=0x0002_0000 (clamp to 1) -> 0xFFFC_0000; t=0xFFFF_0000 (clamp to 0) -> 0x0004_0000.
- in_dz=1 with a0=0x0007_8000, a1=0x0000_0000, t=0x0005_0000 -> out_value=0x0007_8000.
- Rounding: a0=0, a1=0x0000_0001, t=0x0000_8000 -> out_value=0x0000_0001 (round half up).
- Fill DEPTH requests without div_valid -> in_ready=0, occupancy=DEPTH, further in_valid ignored. Then DEPTH back-to-back div_valid -> DEPTH consecutive out_valid in issue order, occupancy=0, in_ready=1.
- Orphan and reset:
  - div_valid with empty FIFO -> no out_valid, err_orphan=1 and stays 1;
  - assert reset asynchronously mid-burst -> out_valid, occupancy and err_orphan go to 0 immediately.
